// File: rtl/regfile_wport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wport_ctrl
//  Description : Write-port sequencer/arbiter for the 32-entry MIPS register
//                file. After reset it zero-fills r1..r31 (the array itself has
//                no reset). It then shares the single write port between the
//                WB stage (priority) and the multi-cycle MDU. It also keeps a
//                pending-write scoreboard of MDU destinations and raises
//                RAW/WAW stalls toward decode.
//  Ports       : clk/rst         - clock, async active-high reset
//                wb_*            - WB stage write request
//                mdu_req/_waddr/_wdata, mdu_ack - MDU write handshake
//                issue_valid/_dst - decode issuing an MDU op
//                raddrA/raddrB   - decode read addresses
//                hazard_stall    - decode stall (combinational)
//                pipe_stall      - MDU starvation stall (registered)
//                init_done       - zero-fill complete (registered)
//                pending         - scoreboard, bit 0 always 0
//                rf_we/_waddr/_wdata - registered regfile write port
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_wport_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [4:0]            wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    input  logic                  mdu_req,
    input  logic [4:0]            mdu_waddr,
    input  logic [DATA_WIDTH-1:0] mdu_wdata,
    output logic                  mdu_ack,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_dst,
    input  logic [4:0]            raddrA,
    input  logic [4:0]            raddrB,
    output logic                  hazard_stall,
    output logic                  pipe_stall,
    output logic                  init_done,
    output logic [31:0]           pending,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SCW-1:0] c_STARVE_MAX = SCW'(STARVE_LIMIT);

    state_t                r_state;
    logic [4:0]            r_cnt;
    logic [SCW-1:0]        r_starve;
    logic [31:0]           r_pending;
    logic                  r_pipe_stall;
    logic                  r_init_done;
    logic                  r_rf_we;
    logic [4:0]            r_rf_waddr;
    logic [DATA_WIDTH-1:0] r_rf_wdata;

    logic                  w_run;
    logic                  w_hazard;
    logic                  w_ack;
    logic                  w_issue_acc;
    logic [SCW-1:0]        w_starve_nxt;
    logic [31:0]           w_pend_nxt;

    assign w_run = (r_state == ST_RUN);

    // Addresses of 0 never hit: pending[0] is held at 0, but the explicit
    // guards keep the intent obvious.
    assign w_hazard = ~w_run
                    | ((raddrA != 5'd0) & r_pending[raddrA])
                    | ((raddrB != 5'd0) & r_pending[raddrB])
                    | (issue_valid & (issue_dst != 5'd0) & r_pending[issue_dst]);

    // WB has fixed priority; the MDU only gets the slot when WB is idle.
    assign w_ack       = w_run & ~wb_we & mdu_req;
    assign w_issue_acc = w_run & issue_valid & ~w_hazard;

    always_comb begin
        w_starve_nxt = '0;
        if (w_run && mdu_req && !w_ack) begin
            if (r_starve >= c_STARVE_MAX) begin
                w_starve_nxt = c_STARVE_MAX;
            end else begin
                w_starve_nxt = r_starve + SCW'(1);
            end
        end
    end

    // Clear is applied before set so a same-cycle set on the same register wins.
    always_comb begin
        w_pend_nxt = r_pending;
        if (w_ack) begin
            w_pend_nxt[mdu_waddr] = 1'b0;
        end
        if (w_issue_acc && (issue_dst != 5'd0)) begin
            w_pend_nxt[issue_dst] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_cnt        <= 5'd1;
            r_starve     <= '0;
            r_pending    <= '0;
            r_pipe_stall <= 1'b0;
            r_init_done  <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= 5'd0;
            r_rf_wdata   <= '0;
        end else begin
            r_starve     <= w_starve_nxt;
            r_pending    <= w_pend_nxt;
            // Registered from the next counter value so the stall shows up the
            // cycle right after the limiting denial and drops right after ack.
            r_pipe_stall <= (w_starve_nxt >= c_STARVE_MAX);
            case (r_state)
                ST_INIT: begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= r_cnt;
                    r_rf_wdata <= '0;
                    r_cnt      <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state     <= ST_RUN;
                        r_init_done <= 1'b1;
                    end
                end
                default: begin
                    if (wb_we) begin
                        r_rf_we    <= (wb_waddr != 5'd0);
                        r_rf_waddr <= wb_waddr;
                        r_rf_wdata <= wb_wdata;
                    end else if (w_ack) begin
                        // r0 target is still acked, just never written.
                        r_rf_we    <= (mdu_waddr != 5'd0);
                        r_rf_waddr <= mdu_waddr;
                        r_rf_wdata <= mdu_wdata;
                    end else begin
                        r_rf_we    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign mdu_ack      = w_ack;
    assign hazard_stall = w_hazard;
    assign pipe_stall   = r_pipe_stall;
    assign init_done    = r_init_done;
    assign pending      = r_pending;
    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wport_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wport_ctrl
//  Description : Self-checking bench for regfile_wport_ctrl. Directed steps
//                followed by a random phase, compared against a behavioural
//                model of the write-port controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wport_ctrl;

    localparam int DW = 32;
    localparam int SL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_we;
    logic [4:0]    wb_waddr;
    logic [DW-1:0] wb_wdata;
    logic          mdu_req;
    logic [4:0]    mdu_waddr;
    logic [DW-1:0] mdu_wdata;
    logic          mdu_ack;
    logic          issue_valid;
    logic [4:0]    issue_dst;
    logic [4:0]    raddrA;
    logic [4:0]    raddrB;
    logic          hazard_stall;
    logic          pipe_stall;
    logic          init_done;
    logic [31:0]   pending;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;

    regfile_wport_ctrl #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .mdu_req(mdu_req), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .mdu_ack(mdu_ack),
        .issue_valid(issue_valid), .issue_dst(issue_dst),
        .raddrA(raddrA), .raddrB(raddrB),
        .hazard_stall(hazard_stall), .pipe_stall(pipe_stall),
        .init_done(init_done), .pending(pending),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          m_done;
    int          m_next;
    bit          m_pend [32];
    int          m_starve;
    bit          e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    bit          e_pipe;
    bit          g_last_ack;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pend_vec();
        logic [31:0] v = '0;
        for (int i = 1; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic model_reset();
        m_done   = 0;
        m_next   = 1;
        m_starve = 0;
        e_pipe   = 0;
        e_we     = 0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        g_last_ack = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_rf_we",      32'(rf_we),        0);
        chk("rst_rf_waddr",   32'(rf_waddr),     0);
        chk("rst_rf_wdata",   rf_wdata,          0);
        chk("rst_init_done",  32'(init_done),    0);
        chk("rst_pipe_stall", 32'(pipe_stall),   0);
        chk("rst_pending",    pending,           0);
        chk("rst_hazard",     32'(hazard_stall), 1);
        chk("rst_mdu_ack",    32'(mdu_ack),      0);
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge.
    task automatic tick();
        bit in_init, e_haz, e_ack, acc;
        #1;
        in_init = !m_done;
        e_haz = in_init
              || (raddrA != 0 && m_pend[raddrA])
              || (raddrB != 0 && m_pend[raddrB])
              || (issue_valid && issue_dst != 0 && m_pend[issue_dst]);
        e_ack = !in_init && !wb_we && mdu_req;
        chk("hazard_stall", 32'(hazard_stall), 32'(e_haz));
        chk("mdu_ack",      32'(mdu_ack),      32'(e_ack));
        g_last_ack = e_ack;

        if (in_init) begin
            e_we   = 1;
            e_addr = 5'(m_next);
            e_data = 0;
            m_next = m_next + 1;
            if (m_next == 32) m_done = 1;
            m_starve = 0;
        end else begin
            if (wb_we) begin
                e_we = (wb_waddr != 0); e_addr = wb_waddr; e_data = wb_wdata;
            end else if (mdu_req) begin
                e_we = (mdu_waddr != 0); e_addr = mdu_waddr; e_data = mdu_wdata;
            end else begin
                e_we = 0;
            end
            if (mdu_req && !e_ack) m_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
            else                   m_starve = 0;
            acc = issue_valid && !e_haz;
            if (e_ack) m_pend[mdu_waddr] = 0;
            if (acc && issue_dst != 0) m_pend[issue_dst] = 1;
        end
        e_pipe = (m_starve >= SL);

        @(posedge clk);
        #1;
        chk("rf_we", 32'(rf_we), 32'(e_we));
        if (e_we) begin
            chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
            chk("rf_wdata", rf_wdata, e_data);
        end
        chk("init_done",  32'(init_done),  32'(m_done));
        chk("pipe_stall", 32'(pipe_stall), 32'(e_pipe));
        chk("pending",    pending,         pend_vec());
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_we = 0; wb_waddr = 0; wb_wdata = 0;
        mdu_req = 0; mdu_waddr = 0; mdu_wdata = 0;
        issue_valid = 0; issue_dst = 0; raddrA = 0; raddrB = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst = 0;

        // Zero-fill sequence r1..r31 (inputs ignored during INIT)
        wb_we = 1; wb_waddr = 5'd4; mdu_req = 1; mdu_waddr = 5'd6; issue_valid = 1; issue_dst = 5'd2;
        repeat (31) tick();
        chk("init_last_addr", 32'(rf_waddr), 31);
        chk("init_done_up",   32'(init_done), 1);
        idle_inputs();
        tick();
        chk("run_idle_we", 32'(rf_we), 0);

        // WB beats MDU, then MDU gets the slot
        wb_we = 1; wb_waddr = 5'd5; wb_wdata = 32'hAAAA0005;
        mdu_req = 1; mdu_waddr = 5'd7; mdu_wdata = 32'h77;
        tick();
        chk("wb_win_addr", 32'(rf_waddr), 5);
        chk("wb_win_data", rf_wdata, 32'hAAAA0005);
        wb_we = 0;
        tick();
        chk("mdu_win_addr", 32'(rf_waddr), 7);
        chk("mdu_win_data", rf_wdata, 32'h77);
        mdu_req = 0;

        // Scoreboard RAW / WAW
        issue_valid = 1; issue_dst = 5'd9;
        tick();
        chk("pend9_set", 32'(pending[9]), 1);
        issue_valid = 0; raddrA = 5'd9;
        tick();
        issue_valid = 1; issue_dst = 5'd9; raddrA = 5'd0;
        tick();
        issue_valid = 0; raddrA = 5'd9;
        mdu_req = 1; mdu_waddr = 5'd9; mdu_wdata = 32'h99;
        tick();
        chk("pend9_clr", 32'(pending[9]), 0);
        mdu_req = 0;
        tick();
        raddrA = 0;

        // Starvation: WB held while MDU waits
        wb_we = 1; wb_waddr = 5'd2; wb_wdata = 32'h1234;
        mdu_req = 1; mdu_waddr = 5'd8; mdu_wdata = 32'h88;
        repeat (6) tick();
        chk("starve_stall", 32'(pipe_stall), 1);
        wb_we = 0;
        tick();
        chk("starve_clear", 32'(pipe_stall), 0);
        mdu_req = 0;

        // r0 targets
        issue_valid = 1; issue_dst = 0;
        wb_we = 1; wb_waddr = 0; wb_wdata = 32'hDEAD;
        mdu_req = 1; mdu_waddr = 0; mdu_wdata = 32'hBEEF;
        tick();
        wb_we = 0;
        tick();
        chk("r0_pending", pending, 0);
        chk("r0_we",      32'(rf_we), 0);
        idle_inputs();

        // Random phase; MDU request held stable until acked
        for (int n = 0; n < 400; n++) begin
            wb_we    = ($urandom % 3) == 0;
            wb_waddr = 5'($urandom);
            wb_wdata = $urandom;
            if (!(mdu_req && !g_last_ack)) begin
                mdu_req   = ($urandom % 2) == 0;
                mdu_waddr = 5'($urandom);
                mdu_wdata = $urandom;
            end
            issue_valid = ($urandom % 3) == 0;
            issue_dst   = 5'($urandom);
            raddrA      = 5'($urandom);
            raddrB      = 5'($urandom);
            tick();
        end

        // Reset in mid-operation
        idle_inputs();
        issue_valid = 1; issue_dst = 5'd3;
        tick();
        issue_valid = 0;
        wb_we = 1; wb_waddr = 5'd10; wb_wdata = 32'h10;
        mdu_req = 1; mdu_waddr = 5'd12; mdu_wdata = 32'hC;
        tick();
        chk("pre_rst_pend3", 32'(pending[3]), 1);
        #2;
        rst = 1;
        #1;
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst = 0;
        wb_we = 0;
        repeat (3) tick();
        chk("reinit_addr", 32'(rf_waddr), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wport_ctrl.md
Name: regfile_wport_ctrl

Overview:
- Sequences and shares the single write port of the 32x DATA_WIDTH, three-ported register file in the pipelined MIPS CPU.
- After reset, it zero-initialises r1..r31, because the register file has no reset.
- During operation, it arbitrates the write port between the writeback (WB) stage and the multi-cycle mult/div unit (MDU).
- It keeps a pending-write scoreboard for MDU destinations and raises a read-after-write / write-after-write stall for the decode stage.

Parameters:
- DATA_WIDTH, 32, register data width
- STARVE_LIMIT, 4, consecutive MDU denials before the pipeline is stalled to free the port

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- wb_we  input  1  WB stage write request
- wb_waddr  input  5  WB destination register
- wb_wdata  input  DATA_WIDTH  WB write data
- mdu_req  input  1  MDU write request; held with addr/data stable until acked
- mdu_waddr  input  5  MDU destination register
- mdu_wdata  input  DATA_WIDTH  MDU result
- mdu_ack  output  1  single-cycle grant to MDU (combinational)
- issue_valid  input  1  decode issuing an MDU op
- issue_dst  input  5  destination of the issued MDU op
- raddrA  input  5  decode read address A (same value driven to regfile)
- raddrB  input  5  decode read address B
- hazard_stall  output  1  decode must stall (combinational)
- pipe_stall  output  1  MDU starvation stall request (registered)
- init_done  output  1  initialisation complete (registered)
- pending  output  32  scoreboard bit per register; bit 0 is always 0
- rf_we  output  1  regfile write enable (registered)
- rf_waddr  output  5  regfile write address (registered)
- rf_wdata  output  DATA_WIDTH  regfile write data (registered)

Behaviour:
- Reset is asynchronous and active-high. Clock is clk. Reset is named rst.
- Reset values:
  - FSM = INIT, init counter = 1
  - rf_we = 0, rf_waddr = 0, rf_wdata = 0
  - init_done = 0, pipe_stall = 0
  - pending = 0, starvation counter = 0
- Reset asserted mid-operation aborts everything and restarts INIT. An in-flight MDU request is neither acked nor written.
- FSM has two states: INIT and RUN.
- INIT:
  - Each cycle, register rf_we = 1, rf_waddr = cnt, rf_wdata = 0, then cnt++.
  - After cnt = 31 is issued, go to RUN and set init_done = 1 (registered together).
  - This gives 31 write cycles, r1..r31 in order. r0 is never written.
  - wb_we, mdu_req and issue_valid are ignored. mdu_ack = 0. hazard_stall = 1.
- RUN, write-port arbitration (fixed priority, WB over MDU):
  - If wb_we = 1: register the WB write.
  - Else if mdu_req = 1: register the MDU write and assert mdu_ack this cycle.
  - Else: register rf_we = 0.
- Latency: a request granted in cycle N appears on rf_* in cycle N+1. The regfile captures it at the end of cycle N+1.
- A write to address 0 from either source produces rf_we = 0 for that slot. An MDU write to r0 is still acked.
- Starvation:
  - The counter increments on each RUN cycle with mdu_req = 1 and no ack.
  - The counter clears on mdu_ack or when mdu_req = 0. It saturates at STARVE_LIMIT.
  - pipe_stall is registered as (counter >= STARVE_LIMIT) and clears the cycle after mdu_ack. WB still wins while wb_we = 1.
- Scoreboard:
  - Issue is accepted when issue_valid = 1, state = RUN and hazard_stall = 0.
  - An accepted issue with issue_dst != 0 sets pending[issue_dst] at the next edge.
  - mdu_ack clears pending[mdu_waddr] at the next edge.
  - If a set and a clear target the same register in the same cycle, the set wins.
  - WB writes never alter pending. pending[0] is hardwired to 0.
- hazard_stall is asserted for any of:
  - state = INIT
  - raddrA != 0 and pending[raddrA]
  - raddrB != 0 and pending[raddrB]
  - issue_valid and issue_dst != 0 and pending[issue_dst] (WAW)
- While hazard_stall = 1, issue_valid is not accepted.

Test Plan:
- Reset, then release rst -> exactly 31 cycles with rf_we = 1 and rf_waddr = 1,2,…,31, all with rf_wdata = 0. init_done rises after the r31 write. hazard_stall = 1 throughout INIT and 0 after.
- RUN, same cycle: wb_we = 1 (r5, 0xAAAA0005) and mdu_req = 1 (r7, 0x77) -> next cycle rf_* = r5/0xAAAA0005 and mdu_ack = 0. Then drop wb_we -> mdu_ack = 1 and the following cycle rf_* = r7/0x77.
- Issue MDU op to dst = 9, then raddrA = 9 -> pending[9] = 1 and hazard_stall = 1. A second issue with dst = 9 is blocked. After mdu_ack with waddr = 9, pending[9] = 0 next cycle and hazard_stall drops.
- Hold wb_we = 1 for 6 cycles with mdu_req = 1 -> pipe_stall = 1 from the cycle after the 4th denial. It stays 1 until mdu_ack, then clears the following cycle.
- issue_dst = 0 with wb_waddr = 0 and mdu_waddr = 0 -> pending stays 0, rf_we stays 0, and mdu_ack still pulses.
- Assert rst during RUN with pending[3] = 1 and mdu_req held -> all outputs return to reset values immediately, and INIT restarts at r1.
